// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, imem and IF/ID bundle
// stall_count/flush_count members exist only with FETCH_PERF_CNT_EN.
interface fetch_stage_if #(
  parameter int N = 32
);
  logic         freeze;
  logic         branch_taken;
  logic [N-1:0] branch_addr;
  logic         flush;
  logic [N-1:0] instruction_in;
  logic [N-1:0] pc_out;
  logic [N-1:0] if_id_pc;
  logic [N-1:0] if_id_instruction;
  logic         if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [N-1:0] stall_count;
  logic [N-1:0] flush_count;
`endif

  modport master (
    input  freeze, branch_taken, branch_addr, flush, instruction_in,
    output pc_out, if_id_pc, if_id_instruction, if_id_valid
`ifdef FETCH_PERF_CNT_EN
    , output stall_count, flush_count
`endif
  );

  modport slave (
    output freeze, branch_taken, branch_addr, flush, instruction_in,
    input  pc_out, if_id_pc, if_id_instruction, if_id_valid
`ifdef FETCH_PERF_CNT_EN
    , input stall_count, flush_count
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register and IF/ID pipeline register
// Optional saturating stall/flush counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  fetch_stage_if.master  bus
);
  logic [N-1:0] pc;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] target;
  logic [N-1:0] if_id_pc_q;
  logic [N-1:0] if_id_instr_q;
  logic         if_id_valid_q;

  assign pc_plus4 = pc + N'(4);
  // Branch targets are forced word-aligned; low address bits are ignored.
  assign target   = bus.branch_addr & ~N'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (bus.branch_taken) begin
      pc <= target;
    end else if (!bus.freeze) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
    end else if (!bus.freeze) begin
      if_id_pc_q    <= pc_plus4;
      if_id_instr_q <= bus.instruction_in;
      if_id_valid_q <= 1'b1;
    end
  end

  assign bus.pc_out            = pc;
  assign bus.if_id_pc          = if_id_pc_q;
  assign bus.if_id_instruction = if_id_instr_q;
  assign bus.if_id_valid       = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [N-1:0] stall_cnt;
  logic [N-1:0] flush_cnt;

  // A flushed cycle counts as a flush only, even if freeze is also high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.flush) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + N'(1);
      end else if (bus.freeze) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + N'(1);
      end
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if #(.N(32)) ifc ();

  fetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   imem = 32'hE3A00014;
      32'h4:   imem = 32'hE3A01A01;
      default: imem = 32'hEA000000 | (a >> 2);
    endcase
  endfunction

  assign ifc.instruction_in = imem(ifc.pc_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v);
    check({tag, ".if_id_pc"}, ifc.if_id_pc, pc);
    check({tag, ".if_id_instruction"}, ifc.if_id_instruction, ins);
    check({tag, ".if_id_valid"}, 32'(ifc.if_id_valid), 32'(v));
  endtask

  initial begin
    rst = 1'b1;
    ifc.freeze = 1'b0;
    ifc.branch_taken = 1'b0;
    ifc.branch_addr = '0;
    ifc.flush = 1'b0;
    step(2);
    check("reset.pc_out", ifc.pc_out, 32'h0);
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("reset.stall_count", ifc.stall_count, 32'h0);
    check("reset.flush_count", ifc.flush_count, 32'h0);
`endif

    rst = 1'b0;
    check("run.pc0", ifc.pc_out, 32'h0);
    step(1);
    check("run.pc1", ifc.pc_out, 32'h4);
    check_ifid("run1", 32'h4, 32'hE3A00014, 1'b1);
    step(1);
    check("run.pc2", ifc.pc_out, 32'h8);
    check_ifid("run2", 32'h8, 32'hE3A01A01, 1'b1);
    step(1);
    check("run.pc3", ifc.pc_out, 32'hC);

    // freeze for three edges at pc_out = 12
    ifc.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("freeze.pc_out", ifc.pc_out, 32'hC);
      check_ifid("freeze", 32'hC, imem(32'h8), 1'b1);
    end
    ifc.freeze = 1'b0;
    step(1);
    check("unfreeze.pc_out", ifc.pc_out, 32'h10);
    check_ifid("unfreeze", 32'h10, imem(32'hC), 1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("freeze.stall_count", ifc.stall_count, 32'd3);
    check("freeze.flush_count", ifc.flush_count, 32'd0);
`endif

    // branch + flush from 0x94 to 0x70
    step(33);
    check("prebranch.pc_out", ifc.pc_out, 32'h94);
    ifc.branch_taken = 1'b1;
    ifc.flush = 1'b1;
    ifc.branch_addr = 32'h70;
    step(1);
    ifc.branch_taken = 1'b0;
    ifc.flush = 1'b0;
    check("branch.pc_out", ifc.pc_out, 32'h70);
    check_ifid("branch", 32'h0, 32'h0, 1'b0);
    step(1);
    check("target.pc_out", ifc.pc_out, 32'h74);
    check_ifid("target", 32'h74, imem(32'h70), 1'b1);

    // branch + flush + freeze with unaligned target
    ifc.branch_taken = 1'b1;
    ifc.flush = 1'b1;
    ifc.freeze = 1'b1;
    ifc.branch_addr = 32'h93;
    step(1);
    ifc.branch_taken = 1'b0;
    ifc.flush = 1'b0;
    ifc.freeze = 1'b0;
    check("triple.pc_out", ifc.pc_out, 32'h90);
    check_ifid("triple", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("triple.stall_count", ifc.stall_count, 32'd3);
    check("triple.flush_count", ifc.flush_count, 32'd2);
`endif
    step(1);
    check("triple_next.pc_out", ifc.pc_out, 32'h94);
    check_ifid("triple_next", 32'h94, imem(32'h90), 1'b1);

    // branch without flush to 0xFFFFFFFC, IF/ID loads normally, then wrap
    ifc.branch_taken = 1'b1;
    ifc.branch_addr = 32'hFFFFFFFE;
    step(1);
    ifc.branch_taken = 1'b0;
    check("noflush.pc_out", ifc.pc_out, 32'hFFFFFFFC);
    check_ifid("noflush", 32'h98, imem(32'h94), 1'b1);
    step(1);
    check("wrap.pc_out", ifc.pc_out, 32'h0);
    check_ifid("wrap", 32'h0, imem(32'hFFFFFFFC), 1'b1);

    // reset mid-run overrides everything
    step(16);
    check("prereset.pc_out", ifc.pc_out, 32'h40);
    rst = 1'b1;
    ifc.freeze = 1'b1;
    ifc.branch_taken = 1'b1;
    ifc.branch_addr = 32'h200;
    step(1);
    rst = 1'b0;
    ifc.freeze = 1'b0;
    ifc.branch_taken = 1'b0;
    check("midreset.pc_out", ifc.pc_out, 32'h0);
    check_ifid("midreset", 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("midreset.stall_count", ifc.stall_count, 32'd0);
    check("midreset.flush_count", ifc.flush_count, 32'd0);
`endif
    step(1);
    check("postreset.pc_out", ifc.pc_out, 32'h4);
    check_ifid("postreset", 32'h4, 32'hE3A00014, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined ARM-subset core. Holds the program counter, presents it to the combinational instruction memory, and captures the returned instruction plus PC+4 into the IF/ID pipeline register for the decode stage. Supports hazard freeze, branch redirect and flush. Optionally keeps stall/flush performance counters.

## Interface
Parameters:
- N, 32, datapath/address width.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock; sole clock of the block.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  hazard stall from the hazard unit; holds PC and IF/ID.
- branch_taken  input  1  redirect request from the execute stage.
- branch_addr  input  N  branch target byte address.
- flush  input  1  invalidates the IF/ID register (driven from branch_taken at top level).
- instruction_in  input  N  instruction returned combinationally by instruction memory for pc_out.
- pc_out  output  N  current PC, addresses instruction memory.
- if_id_pc  output  N  PC+4 of the captured instruction.
- if_id_instruction  output  N  captured instruction word.
- if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- stall_count  output  N  cycles spent frozen (only with FETCH_PERF_CNT_EN).
- flush_count  output  N  flush cycles (only with FETCH_PERF_CNT_EN).

## Operation
- PC register, updated every rising edge, priority highest first:
  - rst: pc <= RESET_PC.
  - branch_taken: pc <= {branch_addr[N-1:2], 2'b00}. Wins over freeze.
  - freeze: pc holds.
  - otherwise: pc <= pc + 4, modulo 2^N. 0xFFFFFFFC wraps to 0x00000000.
- pc_out = pc register (registered output, no combinational path from inputs).
- IF/ID register, priority highest first:
  - rst: if_id_instruction <= 0, if_id_pc <= 0, if_id_valid <= 0.
  - flush: same values as reset. Wins over freeze.
  - freeze: all three hold.
  - otherwise: if_id_instruction <= instruction_in, if_id_pc <= pc + 4 (wrapped), if_id_valid <= 1.
- A bubble carries instruction 0 with valid 0; decode must gate on if_id_valid, not on the instruction word.
- Simultaneous branch_taken and flush (normal redirect): PC loads target, IF/ID becomes a bubble. The instruction at the target is captured on the following edge.
- branch_taken without flush: PC redirects and the IF/ID register loads normally. This is legal but not used by the core.
- Reset asserted mid-operation overrides every other input on that edge. No state survives it.

## Timing
- Reset values: pc_out = RESET_PC, if_id_pc = 0, if_id_instruction = 0, if_id_valid = 0, counters = 0.
- Fetch latency: 1 cycle. The instruction at pc_out in cycle k appears on if_id_* after edge k.
- First edge after rst deasserts: IF/ID holds the word at RESET_PC, if_id_pc = RESET_PC+4, and pc_out = RESET_PC+4.
- Branch penalty: branch_taken sampled at edge k gives pc_out = target after k. The target instruction is valid in IF/ID after edge k+1.
- Freeze held for m cycles: pc_out and IF/ID are unchanged for exactly m edges. Fetch resumes on the first edge with freeze = 0.
- instruction_in must settle within the same cycle as pc_out. No handshake.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - stall_count and flush_count exist.
  - stall_count increments on each edge where rst = 0, flush = 0 and freeze = 1.
  - flush_count increments on each edge where rst = 0 and flush = 1.
  - Both counters saturate at 2^N−1 and clear on rst.
- FETCH_PERF_CNT_EN undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan
- Reset then free-run against the core's program memory:
  - pc_out sequence is 0, 4, 8.
  - After the first edge, if_id_instruction = 0xE3A00014, if_id_pc = 4, valid = 1.
  - After the second edge, if_id_instruction = 0xE3A01A01, if_id_pc = 8.
- Freeze for 3 cycles while pc_out = 12: pc_out stays 12 and IF/ID is unchanged for 3 edges, then pc_out = 16. With the macro on, stall_count = 3.
- branch_taken = flush = 1 with branch_addr = 0x70 at pc_out = 0x94:
  - Next cycle: pc_out = 0x70, valid = 0, instruction = 0.
  - Following edge: IF/ID = imem[0x70], if_id_pc = 0x74, valid = 1.
- branch_taken, flush and freeze all asserted, branch_addr = 0x93: pc_out = 0x90, valid = 0. With the macro on, flush_count increments by 1 and stall_count does not change.
- Wrap-around: force pc to 0xFFFFFFFC via a branch, then run one free edge: pc_out = 0, if_id_pc = 0.
- rst pulsed for one cycle mid-run at pc_out = 0x40: pc_out = RESET_PC, all IF/ID fields = 0, counters = 0.
